// File: rtl/key_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// frame classification and the snapshot classifier.
package key_scan_pkg;

  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 4;
  localparam int SNAP_W     = KEY_ROWS * KEY_COLS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } scan_state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_class_e;

  typedef struct packed {
    frame_class_e            cls;
    logic [KEY_CODE_W-1:0]   code;
  } frame_info_t;

  // Hit count saturates at two; code is only meaningful for SINGLE.
  function automatic frame_info_t classify_frame(input logic [SNAP_W-1:0] snap);
    frame_info_t info;
    logic [1:0]  hits;
    info.code = '0;
    hits      = 2'd0;
    for (int i = 0; i < SNAP_W; i++) begin
      if (snap[i]) begin
        info.code = KEY_CODE_W'(i);
        if (hits != 2'd2) begin
          hits = hits + 2'd1;
        end
      end
    end
    case (hits)
      2'd0:    info.cls = NONE;
      2'd1:    info.cls = SINGLE;
      default: info.cls = MULTI;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/key_frame_capture.sv
// Row-scan divider and snapshot capture: drives one row low per slot,
// samples the columns at slot end and classifies each completed frame.
module key_frame_capture
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV = 5000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_COLS-1:0]  col_in,
  output logic [KEY_ROWS-1:0]  row_out,
  output logic                 frame_done,
  output frame_info_t          frame_info
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int ROW_W = $clog2(KEY_ROWS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(KEY_ROWS - 1);

  logic [DIV_W-1:0]    div_cnt_r;
  logic [ROW_W-1:0]    row_idx_r;
  logic [SNAP_W-1:0]   snapshot_r;
  logic [KEY_ROWS-1:0] row_out_r;
  logic                sample_s;
  logic [SNAP_W-1:0]   frame_snap_s;

  assign sample_s   = (div_cnt_r == DIV_LAST);
  assign frame_done = sample_s && (row_idx_r == ROW_LAST);
  assign row_out    = row_out_r;

  // The last row is classified straight from the pins so the frame ends on its own sample cycle.
  always_comb begin
    frame_snap_s = snapshot_r;
    frame_snap_s[(KEY_ROWS-1)*KEY_COLS +: KEY_COLS] = ~col_in;
  end

  assign frame_info = classify_frame(frame_snap_s);

  // Slot divider, one-cold row rotation and end-of-slot column sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r  <= '0;
      row_idx_r  <= '0;
      snapshot_r <= '0;
      row_out_r  <= 4'b1110;
    end else if (sample_s) begin
      div_cnt_r  <= '0;
      row_idx_r  <= row_idx_r + ROW_W'(1);
      row_out_r  <= {row_out_r[KEY_ROWS-2:0], row_out_r[KEY_ROWS-1]};
      snapshot_r[row_idx_r*KEY_COLS +: KEY_COLS] <= ~col_in;
    end else begin
      div_cnt_r  <= div_cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 keypad scanner top: frame-level debounce FSM producing a held key
// code, a one-cycle press pulse and a key-down flag.
module matrix_key_scan
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 5000,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KEY_COLS-1:0]    col_in,
  output logic [KEY_ROWS-1:0]    row_out,
  output logic [KEY_CODE_W-1:0]  key_code,
  output logic                   key_valid,
  output logic                   key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);

  logic                  frame_done_s;
  frame_info_t           frame_info_s;
  scan_state_e           state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_inc_s;
  logic [KEY_CODE_W-1:0] cand_r;
  logic [KEY_CODE_W-1:0] key_code_r;
  logic                  key_valid_r;
  logic                  key_held_r;

  key_frame_capture #(
    .SCAN_DIV (SCAN_DIV)
  ) u_capture (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_in     (col_in),
    .row_out    (row_out),
    .frame_done (frame_done_s),
    .frame_info (frame_info_s)
  );

  assign cnt_inc_s = (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + CNT_ONE;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

  // Debounce FSM; advances only on frame end, outputs registered with the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      cand_r      <= '0;
      key_code_r  <= '0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (frame_done_s) begin
        case (state_r)
          IDLE: begin
            if (frame_info_s.cls == SINGLE) begin
              cand_r <= frame_info_s.code;
              cnt_r  <= CNT_ONE;
              if (DEBOUNCE_CNT == 1) begin
                state_r     <= PRESSED;
                key_code_r  <= frame_info_s.code;
                key_valid_r <= 1'b1;
                key_held_r  <= 1'b1;
              end else begin
                state_r <= DEB_PRESS;
              end
            end else begin
              state_r <= IDLE;
            end
          end
          DEB_PRESS: begin
            if (frame_info_s.cls == SINGLE && frame_info_s.code == cand_r) begin
              cnt_r <= cnt_inc_s;
              if (cnt_inc_s == CNT_MAX) begin
                state_r     <= PRESSED;
                key_code_r  <= frame_info_s.code;
                key_valid_r <= 1'b1;
                key_held_r  <= 1'b1;
              end else begin
                state_r <= DEB_PRESS;
              end
            end else if (frame_info_s.cls == SINGLE) begin
              cand_r <= frame_info_s.code;
              cnt_r  <= CNT_ONE;
            end else begin
              state_r <= IDLE;
              cnt_r   <= '0;
            end
          end
          PRESSED: begin
            if (frame_info_s.cls == NONE) begin
              if (DEBOUNCE_CNT == 1) begin
                state_r    <= IDLE;
                cnt_r      <= '0;
                key_held_r <= 1'b0;
              end else begin
                state_r <= DEB_REL;
                cnt_r   <= CNT_ONE;
              end
            end else begin
              state_r <= PRESSED;
            end
          end
          DEB_REL: begin
            if (frame_info_s.cls == NONE) begin
              if (cnt_inc_s == CNT_MAX) begin
                state_r    <= IDLE;
                cnt_r      <= '0;
                key_held_r <= 1'b0;
              end else begin
                cnt_r <= cnt_inc_s;
              end
            end else begin
              state_r <= PRESSED;
            end
          end
          default: begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            key_held_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/matrix_key_scan.md
Name: matrix_key_scan

Overview:
- Scanner for the board's 4x4 matrix keypad. It is the input-side counterpart of the 8x8 LED matrix row-scan driver.
- Drives one keypad row low at a time and samples the column lines, building a 16-bit snapshot every frame.
- Debounces the snapshot across whole frames and presents a single-key code with a one-cycle press pulse.
- Feeds the game controller, which owns game_state.

Parameters:
- SCAN_DIV, 5000, clk cycles per row slot (minimum 2).
- DEBOUNCE_CNT, 3, consecutive identical frames needed to accept a press or a release (minimum 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- col_in  in  4  keypad columns, active-low, externally pulled up. col_in[j]==0 means a key in column j of the driven row is closed.
- row_out  out  4  one-cold row drive; row_out[r]==0 selects row r.
- key_code  out  4  code of the accepted key, row*4+col. Held until the next accepted press.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_held  out  1  high while an accepted key is considered down.

Behaviour:
- Reset values: row_out=4'b1110, key_code=0, key_valid=0, key_held=0. Divider, row index, snapshot, debounce count, candidate and state are all cleared; state=IDLE.
- Row scan:
  - div_cnt counts 0..SCAN_DIV-1.
  - When div_cnt==SCAN_DIV-1, the row index advances 0->1->2->3->0 and row_out rotates 1110->1101->1011->0111->1110.
- Sampling:
  - On the cycle div_cnt==SCAN_DIV-1, invert col_in and store it into snapshot bits [4r+3:4r] for the current row r.
  - Sampling at the end of the slot gives the lines SCAN_DIV-1 cycles to settle.
- Frame end:
  - The sample cycle of row 3 completes a frame; frame = 4*SCAN_DIV cycles.
  - The frame is classified using the full snapshot, including the row-3 bits written that cycle:
    - NONE: zero bits set.
    - SINGLE(code): exactly one bit set.
    - MULTI: two or more bits set.
  - The FSM updates only at frame end.
- FSM transitions (all at frame end):
  - IDLE:
    - SINGLE(c): cand=c, cnt=1. If DEBOUNCE_CNT==1, go to PRESSED and accept; otherwise go to DEB_PRESS.
    - NONE or MULTI: stay in IDLE.
  - DEB_PRESS:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_CNT, go to PRESSED and accept.
    - SINGLE(other): cand=other, cnt=1, stay in DEB_PRESS.
    - NONE or MULTI: return to IDLE, cnt=0.
  - PRESSED:
    - NONE: cnt=1. If DEBOUNCE_CNT==1, go to IDLE; otherwise go to DEB_REL.
    - SINGLE or MULTI: stay in PRESSED. No new event, even if the key changes.
  - DEB_REL:
    - NONE: cnt++. When cnt reaches DEBOUNCE_CNT, go to IDLE.
    - SINGLE or MULTI: return to PRESSED, with no pulse.
- Accept action:
  - key_code<=cand on the same cycle as the frame end.
  - key_valid high for exactly the one following cycle.
  - Latency from a clean press that began before a frame's row-0 sample: key_valid high 1 cycle after the frame end of the DEBOUNCE_CNT-th frame.
- key_held: high in PRESSED and DEB_REL, low in IDLE and DEB_PRESS. It changes on the cycle after the frame-end transition, aligned with key_valid.
- A new press event requires passing through IDLE first; a direct key-to-key roll never produces a second pulse.
- Reset asserted mid-operation, in any state or slot: all registers return to reset values immediately and asynchronously. No pulse is emitted during or after deassertion until a full debounce completes again.
- Counter widths:
  - div_cnt: $clog2(SCAN_DIV).
  - cnt: $clog2(DEBOUNCE_CNT+1), saturating at DEBOUNCE_CNT.

Decomposition:
- Shared package key_scan_pkg holds:
  - state enum {IDLE, DEB_PRESS, PRESSED, DEB_REL};
  - constants KEY_ROWS=4, KEY_COLS=4, KEY_CODE_W=4;
  - the frame class enum {NONE, SINGLE, MULTI}.
- One sub-module: key_frame_capture. It owns the divider, row rotation, snapshot register, and frame_done/class/code outputs.
- The top level holds the debounce FSM and the output registers.

Test Plan:
- Bench setup: SCAN_DIV=4, DEBOUNCE_CNT=3 (frame = 16 cycles). A behavioural keypad model drives col_in[j]=0 iff a closed key (r,j) exists with row_out[r]==0.
- Reset and scan: release rst_n -> row_out=1110 for 4 cycles, then 1101, 1011, 0111, and back to 1110 at cycle 16; key_valid=0, key_held=0, key_code=0 throughout.
- Clean press: close key row2/col1 before the frame start -> exactly one key_valid pulse 1 cycle after the 3rd frame end; key_code=9; key_held=1 from the same cycle.
- Press bounce: key present 2 frames, absent 1 frame, present 3 frames -> a single pulse, after the final 3rd present frame; no pulse earlier.
- Multi-key: keys 0 and 5 closed together from IDLE for 6 frames -> no key_valid; key_held stays 0; key_code stays 0.
- Release bounce and roll:
  - Held key 9: open 1 frame, close 1 frame -> key_held stays 1, no pulse.
  - Roll to key 14 -> no pulse, key_code stays 9.
  - Open 3 frames -> key_held falls 1 cycle after the 3rd frame end.
- Reset mid-debounce: assert rst_n=0 during DEB_PRESS (cnt=2), mid-slot -> outputs immediately at reset values. After release with the key still closed, the pulse appears only after 3 fresh full frames.
